mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs (destination, write-enable, ALU result) plus the memory op, address and store data.
- Issues data-bus transactions with a req/gnt/rvalid handshake.
- Stalls the pipeline until each access completes.
- Presents write-back data to the MEM/WB register.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_load_align.sv | 29 ++
 rtl/mem_stage_lsu.sv | 179 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage load/store unit: memory ops, FSM states
// and the write-back "no-op" constants.
package mem_stage_pkg;

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'd0;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half/word out of a loaded bus word and
// sign- or zero-extends it to a 32-bit write-back value.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] wb_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (op)
      MEM_OP_LB:  wb_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: wb_data = {24'h000000, byte_sel};
      MEM_OP_LH:  wb_data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: wb_data = {16'h0000, half_sel};
      MEM_OP_LW:  wb_data = rdata;
      default:    wb_data = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid bus master that stalls the pipe per access.
// Optional MISALIGN_EXC_EN adds misalign_exc and suppresses misaligned half/word accesses.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int BUS_AW      = 32,
  parameter int ACC_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_op,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_sdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
`ifdef MISALIGN_EXC_EN
  output logic              misalign_exc,
`endif
  output logic              stall_req,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata
);

  logic [1:0]  state_reg, state_next;
  logic [7:0]  tmo_reg, tmo_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        abort_reg, abort_next;

  logic        is_ld, is_st, is_acc, misaligned, tmo_hit;
  logic [3:0]  be_w;
  logic [31:0] sdata_w;
  logic [31:0] load_data;

  assign is_ld   = op_is_load(mem_op);
  assign is_st   = op_is_store(mem_op);
  assign is_acc  = (mem_op != MEM_OP_NONE) && (is_ld || is_st);
  assign tmo_hit = (tmo_reg == 8'(ACC_TIMEOUT));

`ifdef MISALIGN_EXC_EN
  assign misaligned = (((mem_op == MEM_OP_LH) || (mem_op == MEM_OP_LHU) || (mem_op == MEM_OP_SH))
                        && mem_addr[0])
                   || (((mem_op == MEM_OP_LW) || (mem_op == MEM_OP_SW)) && (mem_addr[1:0] != 2'b00));
  assign misalign_exc = resetn && (state_reg == ST_IDLE) && misaligned;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    case (mem_op)
      MEM_OP_SB: be_w = 4'b0001 << mem_addr[1:0];
      MEM_OP_SH: be_w = mem_addr[1] ? 4'b1100 : 4'b0011;
      MEM_OP_SW: be_w = 4'b1111;
      default:   be_w = 4'b0000;
    endcase
  end

  // Replicate the store operand so every enabled lane carries the right byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign sdata_w[8*gi +: 8] = (mem_op == MEM_OP_SB) ? mem_sdata[7:0] :
                                (mem_op == MEM_OP_SH) ? mem_sdata[8*(gi%2) +: 8] :
                                                        mem_sdata[8*gi +: 8];
  end

  mem_load_align u_align (
    .op      (mem_op),
    .addr_lo (mem_addr[1:0]),
    .rdata   (rdata_reg),
    .wb_data (load_data)
  );

  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    abort_next = abort_reg;
    case (state_reg)
      ST_IDLE: begin
        if (is_acc && !misaligned) begin
          state_next = ST_REQ;
          abort_next = 1'b0;
        end
      end
      ST_REQ: begin
        if (tmo_hit) begin
          state_next = ST_DONE;
          abort_next = 1'b1;
        end else if (bus_gnt) begin
          state_next = is_st ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmo_hit) begin
          state_next = ST_DONE;
          abort_next = 1'b1;
        end else if (bus_rvalid) begin
          rdata_next = bus_rdata;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // The counter only measures time spent in the current REQ or WAIT visit.
    if (state_next != state_reg) begin
      tmo_next = 8'd0;
    end else if ((state_reg == ST_REQ) || (state_reg == ST_WAIT)) begin
      tmo_next = tmo_reg + 8'd1;
    end else begin
      tmo_next = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      tmo_reg   <= 8'd0;
      rdata_reg <= ZeroWord;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      rdata_reg <= rdata_next;
      abort_reg <= abort_next;
    end
  end

  // All outputs are gated by resetn so a reset mid-access clears them at once.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'b0000;
    bus_wdata = ZeroWord;
    stall_req = 1'b0;
    wb_wd     = NOPRegAddr;
    wb_wreg   = 1'b0;
    wb_wdata  = ZeroWord;
    if (resetn) begin
      case (state_reg)
        ST_IDLE: begin
          if (!is_acc) begin
            wb_wd    = mem_wd;
            wb_wreg  = mem_wreg;
            wb_wdata = mem_wdata;
          end else if (misaligned) begin
            wb_wd = mem_wd;
          end else begin
            stall_req = 1'b1;
          end
        end
        ST_REQ: begin
          stall_req = 1'b1;
          bus_req   = !tmo_hit;
          bus_we    = is_st;
          bus_addr  = {mem_addr[BUS_AW-1:2], 2'b00};
          bus_be    = be_w;
          bus_wdata = sdata_w;
        end
        ST_WAIT: stall_req = 1'b1;
        default: begin
          wb_wd = mem_wd;
          if (is_ld && !abort_reg) begin
            wb_wreg  = mem_wreg;
            wb_wdata = load_data;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: driver queues expected write-back/bus
// behaviour, a negedge monitor checks it, a responder models the data bus.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_op = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_sdata = '0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall_req;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
`ifdef MISALIGN_EXC_EN
  logic        misalign_exc;
`endif

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_wd     (mem_wd),
    .mem_wreg   (mem_wreg),
    .mem_wdata  (mem_wdata),
    .mem_op     (mem_op),
    .mem_addr   (mem_addr),
    .mem_sdata  (mem_sdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
`ifdef MISALIGN_EXC_EN
    .misalign_exc (misalign_exc),
`endif
    .stall_req  (stall_req),
    .wb_wd      (wb_wd),
    .wb_wreg    (wb_wreg),
    .wb_wdata   (wb_wdata)
  );

  typedef struct {
    int          id;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          stalls;
    int          reqs;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] bwdata;
    logic        chk_bwdata;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          txn_id = 0;
  logic        cur_valid = 1'b0;
  int          cfg_gnt_delay = 0;
  int          cfg_rv_delay = 0;
  logic [31:0] cfg_rdata = '0;
  logic        force_late_rv = 1'b0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s txn%0d: got 0x%08h, expected 0x%08h", name, id, act, req);
    end
  endtask

  // Monitor: checks bus fields every request cycle, write-back at completion.
  initial begin
    int   stall_cnt;
    int   req_cnt;
    exp_t e;
    stall_cnt = 0;
    req_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!resetn || !cur_valid || exp_q.size() == 0) begin
        stall_cnt = 0;
        req_cnt   = 0;
        continue;
      end
      if (bus_req) begin
        req_cnt++;
        chk("bus_addr", exp_q[0].id, bus_addr, exp_q[0].addr);
        chk("bus_be", exp_q[0].id, 32'(bus_be), 32'(exp_q[0].be));
        chk("bus_we", exp_q[0].id, 32'(bus_we), 32'(exp_q[0].we));
        if (exp_q[0].chk_bwdata) chk("bus_wdata", exp_q[0].id, bus_wdata, exp_q[0].bwdata);
      end
      if (stall_req) begin
        stall_cnt++;
      end else begin
        e = exp_q.pop_front();
        $display("[TB] txn%0d wd=%0d wreg=%0b wdata=0x%08h stalls=%0d reqs=%0d",
                 e.id, wb_wd, wb_wreg, wb_wdata, stall_cnt, req_cnt);
        chk("wb_wd", e.id, 32'(wb_wd), 32'(e.wd));
        chk("wb_wreg", e.id, 32'(wb_wreg), 32'(e.wreg));
        if (e.chk_wdata) chk("wb_wdata", e.id, wb_wdata, e.wdata);
        chk("stall_cycles", e.id, 32'(stall_cnt), 32'(e.stalls));
        chk("req_cycles", e.id, 32'(req_cnt), 32'(e.reqs));
`ifdef MISALIGN_EXC_EN
        chk("misalign_exc", e.id, 32'(misalign_exc), 32'(e.mis));
`endif
        stall_cnt = 0;
        req_cnt   = 0;
        done_cnt++;
      end
    end
  end

  // Bus responder: grants after cfg_gnt_delay request cycles, returns load data
  // cfg_rv_delay cycles after the first WAIT cycle.
  initial begin
    int wcnt;
    int rcnt;
    bit rv_pending;
    wcnt = 0;
    rcnt = 0;
    rv_pending = 0;
    forever begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      if (!resetn) begin
        wcnt = 0;
        rv_pending = 0;
      end else if (force_late_rv) begin
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_BEEF;
      end else if (rv_pending) begin
        if (rcnt == cfg_rv_delay) begin
          bus_rvalid = 1'b1;
          bus_rdata  = cfg_rdata;
          rv_pending = 0;
        end else begin
          rcnt++;
        end
      end else if (bus_req) begin
        if (wcnt == cfg_gnt_delay) begin
          bus_gnt = 1'b1;
          wcnt = 0;
          if (!bus_we) begin
            rv_pending = 1;
            rcnt = 0;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] sdata,
                       input int gd, input int rd, input logic [31:0] rdata,
                       input logic e_wreg, input logic [31:0] e_wdata, input logic chk_wdata,
                       input int stalls, input int reqs, input logic [3:0] be,
                       input logic [31:0] bwdata, input logic chk_bw, input logic mis);
    exp_t e;
    int   d0;
    bit   ok;
    e.id = txn_id;
    txn_id++;
    e.wd = wd;
    e.wreg = e_wreg;
    e.wdata = e_wdata;
    e.chk_wdata = chk_wdata;
    e.stalls = stalls;
    e.reqs = reqs;
    e.addr = {addr[31:2], 2'b00};
    e.be = be;
    e.we = (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
    e.bwdata = bwdata;
    e.chk_bwdata = chk_bw;
    e.mis = mis;
    exp_q.push_back(e);
    cfg_gnt_delay = gd;
    cfg_rv_delay = rd;
    cfg_rdata = rdata;
    mem_op = op;
    mem_wd = wd;
    mem_wreg = wreg;
    mem_wdata = wdata;
    mem_addr = addr;
    mem_sdata = sdata;
    cur_valid = 1'b1;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL completion txn%0d: got no completion in 400 cycles, expected one", e.id);
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: an access op on the inputs must not leak through while resetn=0.
    mem_op = 4'd5;
    mem_wd = 5'd7;
    mem_wreg = 1'b1;
    mem_wdata = 32'h99;
    #3;
    chk("rst_bus_req", -1, 32'(bus_req), 32'd0);
    chk("rst_bus_we", -1, 32'(bus_we), 32'd0);
    chk("rst_bus_be", -1, 32'(bus_be), 32'd0);
    chk("rst_stall_req", -1, 32'(stall_req), 32'd0);
    chk("rst_wb_wd", -1, 32'(wb_wd), 32'd0);
    chk("rst_wb_wreg", -1, 32'(wb_wreg), 32'd0);
    chk("rst_wb_wdata", -1, wb_wdata, 32'd0);
    mem_op = 4'd0;
    @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    //     op     wd     wreg  wdata          addr           sdata          gd  rd  rdata          ewreg ewdata        cw st   rq  be       bwdata         cb mis
    issue(4'd0,  5'd5,  1'b1, 32'h0000_1234, 32'h0,         32'h0,         0,  0,  32'h0,         1'b1, 32'h0000_1234, 1, 0,   0,  4'h0,    32'h0,         0, 0);
    issue(4'd12, 5'd9,  1'b0, 32'hCAFE_F00D, 32'h0,         32'h0,         0,  0,  32'h0,         1'b0, 32'hCAFE_F00D, 1, 0,   0,  4'h0,    32'h0,         0, 0);
    issue(4'd1,  5'd3,  1'b1, 32'h0000_0055, 32'h0000_0103, 32'h0,         0,  0,  32'h80FF_FF7F, 1'b1, 32'hFFFF_FF80, 1, 3,   1,  4'b0000, 32'h0,         0, 0);
    issue(4'd7,  5'd4,  1'b1, 32'h0,         32'h0000_0022, 32'hAAAA_BEEF, 3,  0,  32'h0,         1'b0, 32'h0,         0, 5,   4,  4'b1100, 32'hBEEF_BEEF, 1, 0);
    issue(4'd4,  5'd10, 1'b1, 32'h0,         32'h0000_0010, 32'h0,         0,  0,  32'h1234_ABCD, 1'b1, 32'h0000_ABCD, 1, 3,   1,  4'b0000, 32'h0,         0, 0);
    issue(4'd5,  5'd11, 1'b1, 32'h0,         32'h0000_0014, 32'h0,         0,  0,  32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF, 1, 3,   1,  4'b0000, 32'h0,         0, 0);
    issue(4'd3,  5'd12, 1'b1, 32'h0,         32'h0000_0012, 32'h0,         0,  0,  32'h8001_7FFF, 1'b1, 32'hFFFF_8001, 1, 3,   1,  4'b0000, 32'h0,         0, 0);
    issue(4'd2,  5'd13, 1'b1, 32'h0,         32'h0000_0101, 32'h0,         0,  0,  32'h0000_9A00, 1'b1, 32'h0000_009A, 1, 3,   1,  4'b0000, 32'h0,         0, 0);
    issue(4'd6,  5'd14, 1'b1, 32'h0,         32'h0000_0203, 32'h1234_5678, 0,  0,  32'h0,         1'b0, 32'h0,         0, 2,   1,  4'b1000, 32'h7878_7878, 1, 0);
    issue(4'd8,  5'd15, 1'b0, 32'h0,         32'h0000_0300, 32'hDEAD_BEEF, 1,  0,  32'h0,         1'b0, 32'h0,         0, 3,   2,  4'b1111, 32'hDEAD_BEEF, 1, 0);
    issue(4'd1,  5'd16, 1'b1, 32'h0,         32'h0000_0102, 32'h0,         1,  2,  32'h0080_0000, 1'b1, 32'hFFFF_FF80, 1, 6,   2,  4'b0000, 32'h0,         0, 0);
    issue(4'd5,  5'd17, 1'b0, 32'h0,         32'h0000_0008, 32'h0,         0,  0,  32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 1, 3,   1,  4'b0000, 32'h0,         0, 0);
    // Bus never grants: 255 request cycles, one dropped-request cycle, then abort.
    issue(4'd5,  5'd18, 1'b1, 32'h0,         32'h0000_0040, 32'h0,         1000, 0, 32'h0,        1'b0, 32'h0,         1, 257, 255, 4'b0000, 32'h0,       0, 0);
`ifdef MISALIGN_EXC_EN
    issue(4'd5,  5'd19, 1'b1, 32'h0,         32'h0000_0002, 32'h0,         0,  0,  32'h0,         1'b0, 32'h0,         0, 0,   0,  4'b0000, 32'h0,         0, 1);
`else
    issue(4'd5,  5'd19, 1'b1, 32'h0,         32'h0000_001A, 32'h0,         0,  0,  32'h1122_3344, 1'b1, 32'h1122_3344, 1, 3,   1,  4'b0000, 32'h0,         0, 0);
`endif

    // Reset while waiting for load data, then a stray rvalid after release.
    cur_valid = 1'b0;
    cfg_gnt_delay = 0;
    cfg_rv_delay = 3;
    cfg_rdata = 32'h0;
    mem_op = 4'd5;
    mem_wd = 5'd20;
    mem_wreg = 1'b1;
    mem_addr = 32'h50;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("stall_in_wait", -1, 32'(stall_req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rstwait_stall_req", -1, 32'(stall_req), 32'd0);
    chk("rstwait_bus_req", -1, 32'(bus_req), 32'd0);
    mem_op = 4'd0;
    mem_wd = 5'd5;
    mem_wreg = 1'b1;
    mem_wdata = 32'h1234;
    #1;
    chk("rstwait_wb_wd", -1, 32'(wb_wd), 32'd0);
    chk("rstwait_wb_wreg", -1, 32'(wb_wreg), 32'd0);
    chk("rstwait_wb_wdata", -1, wb_wdata, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b1;
    force_late_rv = 1'b1;
    @(posedge clk);
    #1 force_late_rv = 1'b0;
    @(negedge clk);
    chk("late_rv_stall", -1, 32'(stall_req), 32'd0);
    chk("late_rv_wb_wdata", -1, wb_wdata, 32'h0000_1234);
    chk("late_rv_wb_wreg", -1, 32'(wb_wreg), 32'd1);
    @(posedge clk);
    #1;

    issue(4'd5,  5'd21, 1'b1, 32'h0,         32'h0000_0060, 32'h0,         0,  0,  32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1, 3,   1,  4'b0000, 32'h0,         0, 0);
    cur_valid = 1'b0;
    mem_op = 4'd0;
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
